// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - whack-a-mole spawner: LFSR hole choice, up/gap/hit timing, score and miss counts
module mole_spawner #(
  parameter int          NUM_HOLES = 18,
  parameter logic [15:0] SEED      = 16'd483,
  parameter int          UP_INIT   = 50_000_000,
  parameter int          UP_MIN    = 10_000_000,
  parameter int          UP_STEP   = 2_000_000,
  parameter int          GAP_CYC   = 25_000_000,
  parameter int          HIT_CYC   = 12_500_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 mole_hit,
  output logic [NUM_HOLES-1:0] LEDR,
  output logic                 mole_up,
  output logic                 hit_flash,
  output logic [7:0]           score,
  output logic [7:0]           misses
);

  localparam int UW     = $clog2(UP_INIT + 1);
  localparam int TMAX_A = (UP_INIT > GAP_CYC) ? UP_INIT : GAP_CYC;
  localparam int TMAX   = (TMAX_A > HIT_CYC) ? TMAX_A : HIT_CYC;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int IW     = $clog2(NUM_HOLES);
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'd1 : SEED;
  localparam logic [NUM_HOLES-1:0] ONE = {{(NUM_HOLES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GAP, UP, HIT} state_t;

  state_t         state;
  logic [TW-1:0]  timer;
  logic [15:0]    lfsr;
  logic [15:0]    lfsr_next;
  logic [UW-1:0]  up_len;
  logic [UW-1:0]  up_len_next;
  logic [UW:0]    up_diff;
  logic [IW-1:0]  prev_idx;
  logic [IW-1:0]  idx_raw;
  logic [IW-1:0]  pick;

  // Hole choice never repeats the previous hole: bump to the neighbour on a collision.
  always_comb begin
    lfsr_next   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    idx_raw     = IW'(lfsr % 16'(NUM_HOLES));
    pick        = idx_raw;
    if (idx_raw == prev_idx)
      pick = (idx_raw == IW'(NUM_HOLES - 1)) ? '0 : idx_raw + IW'(1);
    up_diff     = {1'b0, up_len} - (UW+1)'(UP_STEP);
    up_len_next = up_diff[UW-1:0];
    if (up_diff[UW] || (up_diff[UW-1:0] < UW'(UP_MIN)))
      up_len_next = UW'(UP_MIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      lfsr      <= SEED_EFF;
      up_len    <= UW'(UP_INIT);
      prev_idx  <= '0;
      LEDR      <= '0;
      mole_up   <= 1'b0;
      hit_flash <= 1'b0;
      score     <= 8'd0;
      misses    <= 8'd0;
    end else begin
      lfsr <= lfsr_next;
      if (!enable) begin
        state     <= IDLE;
        LEDR      <= '0;
        mole_up   <= 1'b0;
        hit_flash <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= GAP;
            timer  <= TW'(GAP_CYC - 1);
            score  <= 8'd0;
            misses <= 8'd0;
            up_len <= UW'(UP_INIT);
          end
          GAP: begin
            if (timer == '0) begin
              state    <= UP;
              timer    <= TW'(up_len) - TW'(1);
              LEDR     <= ONE << pick;
              mole_up  <= 1'b1;
              prev_idx <= pick;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          UP: begin
            // A hit on the final up cycle still wins over the timeout.
            if (mole_hit) begin
              state     <= HIT;
              timer     <= TW'(HIT_CYC - 1);
              LEDR      <= '0;
              mole_up   <= 1'b0;
              hit_flash <= 1'b1;
              up_len    <= up_len_next;
              if (score != 8'hFF) score <= score + 8'd1;
            end else if (timer == '0) begin
              state   <= GAP;
              timer   <= TW'(GAP_CYC - 1);
              LEDR    <= '0;
              mole_up <= 1'b0;
              if (misses != 8'hFF) misses <= misses + 8'd1;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          HIT: begin
            if (timer == '0) begin
              state     <= GAP;
              timer     <= TW'(GAP_CYC - 1);
              hit_flash <= 1'b0;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
